// File: rtl/vga_grad_filter.sv
// Per-channel gradient filter for the VGA stream: horizontal, vertical (one-line buffer)
// or saturated sum, with all sync/blank signals delayed to stay aligned (2-cycle latency).
module vga_grad_filter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = 8
) (
    input  logic          VGA_CLK,
    input  logic          reset_n,
    input  logic [CW-1:0] iVGA_R,
    input  logic [CW-1:0] iVGA_G,
    input  logic [CW-1:0] iVGA_B,
    input  logic          iVGA_HS,
    input  logic          iVGA_VS,
    input  logic          iVGA_SYNC_N,
    input  logic          iVGA_BLANK_N,
    input  logic [1:0]    mode,
    input  logic [2:0]    chan_en,
    output logic [CW-1:0] oVGA_R,
    output logic [CW-1:0] oVGA_G,
    output logic [CW-1:0] oVGA_B,
    output logic          oVGA_HS,
    output logic          oVGA_VS,
    output logic          oVGA_SYNC_N,
    output logic          oVGA_BLANK_N,
    output logic [1:0]    active_mode,
    output logic          line_err
);

    localparam int AW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNTW = AW + 1;
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PW   = 3 * CW;
    localparam logic [CNTW-1:0] COL_END = CNTW'(WIDTH);
    localparam logic [RW-1:0]   ROW_MAX = RW'(HEIGHT - 1);

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [CW-1:0] pick(input logic [1:0] m, input logic [CW-1:0] raw,
                                           input logic [CW-1:0] h, input logic [CW-1:0] v);
        logic [CW:0] sum;
        sum = {1'b0, h} + {1'b0, v};
        case (m)
            2'd0:    pick = raw;
            2'd1:    pick = h;
            2'd2:    pick = v;
            default: pick = sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
        endcase
    endfunction

    logic [CNTW-1:0] col;
    logic [RW-1:0]   row;
    logic            first_line;
    logic            vs_d;
    logic            blank_d;
    logic            col_ok;
    logic [AW-1:0]   lb_addr;
    logic [PW-1:0]   pix_in;
    logic [PW-1:0]   prev_pix;
    logic [PW-1:0]   lb_rd;
    logic [PW-1:0]   h_c;
    logic [PW-1:0]   v_c;
    logic [PW-1:0]   line_buf [WIDTH];

    logic [PW-1:0]   s1_pix;
    logic [PW-1:0]   s1_h;
    logic [PW-1:0]   s1_v;
    logic [2:0]      s1_en;
    logic            s1_hs;
    logic            s1_vs;
    logic            s1_sync;
    logic            s1_blank;
    logic [PW-1:0]   out_c;

    assign pix_in  = {iVGA_R, iVGA_G, iVGA_B};
    assign col_ok  = (col < COL_END);
    assign lb_addr = col_ok ? col[AW-1:0] : '0;
    assign lb_rd   = line_buf[lb_addr];

    // Pixels past WIDTH keep counting as non-zero columns but never touch the line buffer.
    always_comb begin
        h_c = '0;
        v_c = '0;
        for (int k = 0; k < 3; k++) begin
            if (col != '0)
                h_c[k*CW +: CW] = abs_diff(pix_in[k*CW +: CW], prev_pix[k*CW +: CW]);
            if (!first_line && col_ok)
                v_c[k*CW +: CW] = abs_diff(pix_in[k*CW +: CW], lb_rd[k*CW +: CW]);
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (iVGA_BLANK_N && col_ok)
            line_buf[lb_addr] <= pix_in;
    end

    // VS low takes priority over the end-of-run row advance.
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            col         <= '0;
            row         <= '0;
            first_line  <= 1'b0;
            vs_d        <= 1'b1;
            blank_d     <= 1'b0;
            prev_pix    <= '0;
            active_mode <= 2'd0;
            line_err    <= 1'b0;
        end else begin
            vs_d     <= iVGA_VS;
            blank_d  <= iVGA_BLANK_N;
            prev_pix <= pix_in;
            if (!iVGA_BLANK_N)
                col <= '0;
            else if (col_ok)
                col <= col + 1'b1;
            if (iVGA_BLANK_N && !col_ok)
                line_err <= 1'b1;
            if (!iVGA_VS) begin
                row        <= '0;
                first_line <= 1'b1;
            end else if (blank_d && !iVGA_BLANK_N) begin
                first_line <= 1'b0;
                if (row < ROW_MAX)
                    row <= row + 1'b1;
            end
            if (vs_d && !iVGA_VS)
                active_mode <= mode;
        end
    end

    always_comb begin
        out_c = '0;
        for (int k = 0; k < 3; k++) begin
            if (s1_blank)
                out_c[k*CW +: CW] = s1_en[k] ?
                    pick(active_mode, s1_pix[k*CW +: CW], s1_h[k*CW +: CW], s1_v[k*CW +: CW]) :
                    s1_pix[k*CW +: CW];
        end
    end

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            s1_pix       <= '0;
            s1_h         <= '0;
            s1_v         <= '0;
            s1_en        <= 3'd0;
            s1_hs        <= 1'b1;
            s1_vs        <= 1'b1;
            s1_sync      <= 1'b0;
            s1_blank     <= 1'b0;
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
            oVGA_SYNC_N  <= 1'b0;
            oVGA_BLANK_N <= 1'b0;
        end else begin
            s1_pix       <= pix_in;
            s1_h         <= h_c;
            s1_v         <= v_c;
            s1_en        <= chan_en;
            s1_hs        <= iVGA_HS;
            s1_vs        <= iVGA_VS;
            s1_sync      <= iVGA_SYNC_N;
            s1_blank     <= iVGA_BLANK_N;
            {oVGA_R, oVGA_G, oVGA_B} <= out_c;
            oVGA_HS      <= s1_hs;
            oVGA_VS      <= s1_vs;
            oVGA_SYNC_N  <= s1_sync;
            oVGA_BLANK_N <= s1_blank;
        end
    end

endmodule

// File: doc/vga_grad_filter.md
Name: vga_grad_filter

Overview:
Parametrised successor to the single-pixel VGA delta filter. Sits in the VGA stream between the video source and the Terasic VGA controller on the 25 MHz VGA_CLK. Per channel, it computes one of three values: the absolute horizontal gradient, the absolute vertical gradient (using an internal one-line buffer), or their saturated sum. All sync and blank signals are delayed to match, so the output stays timing-aligned.

Parameters:
WIDTH, 640, active pixels per line; sets line-buffer depth.
HEIGHT, 480, active lines per frame; sets the row-counter range.
CW, 8, bits per colour channel.

Ports:
VGA_CLK  in  1  pixel clock; all logic on posedge.
reset_n  in  1  asynchronous, active-low reset.
iVGA_R / iVGA_G / iVGA_B  in  CW each  input colours; 0 while blanked.
iVGA_HS  in  1  horizontal sync; low between lines.
iVGA_VS  in  1  vertical sync; low between frames.
iVGA_SYNC_N  in  1  always 0.
iVGA_BLANK_N  in  1  high during active pixels.
mode  in  2  requested mode: 0 pass, 1 horizontal, 2 vertical, 3 sum.
chan_en  in  3  per-channel filter enable; bit2 = R, bit1 = G, bit0 = B.
oVGA_R / oVGA_G / oVGA_B  out  CW each  output colours.
oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N  out  1 each  delayed sync/blank.
active_mode  out  2  mode currently applied.
line_err  out  1  sticky flag: a line exceeded WIDTH active pixels.

Behaviour:
- Reset (asynchronous, reset_n low):
  - Colour outputs = 0; oVGA_HS = 1; oVGA_VS = 1; oVGA_SYNC_N = 0; oVGA_BLANK_N = 0.
  - active_mode = 0; line_err = 0.
  - Column/row counters, first-line flag and pipeline registers all cleared.
  - Line-buffer contents are don't-care; the first-line rule below masks them.
- Latency: fixed 2 cycles for every output. A signal sampled at edge t appears at edge t+2, in all modes. No stall and no handshake.
- Column counter col:
  - Increments on each active input pixel (iVGA_BLANK_N = 1).
  - Clears to 0 on any cycle with iVGA_BLANK_N = 0.
- Row counter row and first_line flag:
  - On iVGA_VS = 0: row = 0, first_line = 1.
  - On the falling edge of iVGA_BLANK_N (end of an active run): row increments and first_line = 0. row saturates at HEIGHT-1.
- Mode latch: active_mode <= mode on the iVGA_VS falling edge only. A mode change mid-frame never tears the image.
- Horizontal gradient h = |p(col) - p(col-1)|. At col = 0, h = 0.
- Vertical gradient v = |p(col, row) - linebuf[col]|.
  - If first_line = 1 or col >= WIDTH, v = 0.
- Line buffer:
  - WIDTH x 3 x CW, read-before-write at the same address.
  - On each active pixel with col < WIDTH: read linebuf[col], then write the raw (unfiltered) input pixel.
- Per-channel result by active_mode:
  - 0: raw pixel.
  - 1: h.
  - 2: v.
  - 3: min(h + v, 2^CW - 1), summed with a CW+1-bit intermediate.
  - A channel whose chan_en bit is 0 outputs its raw pixel, delayed.
  - chan_en is sampled every cycle; no frame latching.
- Blanking: when the delayed blank is 0, all colour outputs are forced to 0, regardless of mode.
- line_err:
  - Set when an active pixel arrives with col >= WIDTH.
  - Cleared only by reset.
  - The excess pixels are still output, with v = 0.
- Simultaneous events: if iVGA_VS falls in the same cycle as iVGA_BLANK_N falls, the VS rule wins: row = 0, first_line = 1.

Test Plan:
1. WIDTH = HEIGHT = 10, CW = 8, input R = x, G = y, B = x+y; mode = 0, chan_en = 7 -> output equals input delayed exactly 2 cycles, including HS/VS/BLANK_N; oVGA_SYNC_N = 0 throughout; colour = 0 when blanked.
2. Same pattern, mode = 1 latched at frame start -> R = 1 for x >= 1 and 0 at x = 0; G = 0 everywhere; B = 1 for x >= 1 and 0 at x = 0.
3. Mode = 2 -> R = 0 everywhere; G = 1 and B = 1 for y >= 1; all channels 0 on row 0 of every frame, including the first frame after reset.
4. Mode = 3 with chan_en = 3'b001 -> B = 2 at x, y >= 1, B = 1 on row 0 or column 0 (except (0,0) = 0); R and G pass raw values.
5. Checkerboard alternating 0/255, mode = 3 -> interior output saturates at 255 and never wraps to 254.
6. Three checks:
   - mode toggled 0 -> 1 mid-frame: output stays passthrough until the next VS falling edge.
   - a line with 12 active pixels: line_err rises and stays high.
   - reset_n pulsed low mid-line: outputs return to reset values immediately, without waiting for a clock edge.
